// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control sequencer.
package mc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXE,
      ST_MEM,
      ST_WB,
      ST_HALT
   } state_t;

   typedef enum logic [3:0] {
      IC_RTYPE,
      IC_JR,
      IC_IALU,
      IC_LW,
      IC_SW,
      IC_BEQ,
      IC_BNE,
      IC_J,
      IC_JAL,
      IC_ILL
   } instr_cls_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [3:0] ALU_NOP = 4'd0;
   localparam logic [3:0] ALU_ADD = 4'd1;
   localparam logic [3:0] ALU_SUB = 4'd2;
   localparam logic [3:0] ALU_AND = 4'd3;
   localparam logic [3:0] ALU_OR  = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;
   localparam logic [3:0] ALU_SLL = 4'd6;
   localparam logic [3:0] ALU_SRL = 4'd7;
   localparam logic [3:0] ALU_LUI = 4'd8;

   localparam logic [1:0] NPC_PC4 = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   localparam logic [1:0] GPR_RD  = 2'd0;
   localparam logic [1:0] GPR_RT  = 2'd1;
   localparam logic [1:0] GPR_R31 = 2'd2;

   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_MEM = 2'd1;
   localparam logic [1:0] WD_PC  = 2'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the controller, slave the datapath side.
interface mc_ctrl_if #(parameter int CNT_W = 32);
   logic [5:0]       Op;
   logic [5:0]       Funct;
   logic             Zero;
   logic             imem_ready;
   logic             dmem_ready;
   logic             imem_req;
   logic             dmem_req;
   logic             IRWrite;
   logic             PCWrite;
   logic             RegWrite;
   logic             MemWrite;
   logic             EXTOp;
   logic [3:0]       ALUOp;
   logic [1:0]       NPCOp;
   logic             ALUSrcA;
   logic             ALUSrcB;
   logic [1:0]       GPRSel;
   logic [1:0]       WDSel;
   logic [CNT_W-1:0] retired;
   logic             halted;

   modport master (
      input  Op, Funct, Zero, imem_ready, dmem_ready,
      output imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite, EXTOp,
             ALUOp, NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel, retired, halted
   );

   modport slave (
      output Op, Funct, Zero, imem_ready, dmem_ready,
      input  imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite, EXTOp,
             ALUOp, NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel, retired, halted
   );
endinterface

// File: rtl/mc_decode.sv
// Combinational Op/Funct decode into an instruction class plus the ALU-side selects.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output instr_cls_t cls,
   output logic [3:0] alu_op,
   output logic       ext_op,
   output logic       alu_src_a,
   output logic       alu_src_b
);

   always_comb begin
      cls       = IC_ILL;
      alu_op    = ALU_NOP;
      ext_op    = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      case (op)
         OP_RTYPE: begin
            cls = IC_RTYPE;
            case (funct)
               FN_ADDU: alu_op = ALU_ADD;
               FN_SUBU: alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               FN_SLL:  begin alu_op = ALU_SLL; alu_src_a = 1'b1; end
               FN_SRL:  begin alu_op = ALU_SRL; alu_src_a = 1'b1; end
               FN_JR:   cls = IC_JR;
               default: cls = IC_ILL;
            endcase
         end
         OP_ADDI: begin cls = IC_IALU; alu_op = ALU_ADD; ext_op = 1'b1; alu_src_b = 1'b1; end
         OP_LW:   begin cls = IC_LW;   alu_op = ALU_ADD; ext_op = 1'b1; alu_src_b = 1'b1; end
         OP_SW:   begin cls = IC_SW;   alu_op = ALU_ADD; ext_op = 1'b1; alu_src_b = 1'b1; end
         OP_ORI:  begin cls = IC_IALU; alu_op = ALU_OR;  alu_src_b = 1'b1; end
         OP_LUI:  begin cls = IC_IALU; alu_op = ALU_LUI; alu_src_b = 1'b1; end
         OP_BEQ:  begin cls = IC_BEQ;  alu_op = ALU_SUB; end
         OP_BNE:  begin cls = IC_BNE;  alu_op = ALU_SUB; end
         OP_J:    cls = IC_J;
         OP_JAL:  cls = IC_JAL;
         default: cls = IC_ILL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer with retired-instruction counter.
// Optional MC_CTRL_ILLEGAL_HALT_EN: unknown instructions park in HALT instead of acting as NOPs.
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_FETCH  | request instruction, load IR and PC+4 on imem_ready
// ST_DECODE | one idle cycle while the RF operands settle
// ST_EXE    | ALU op; branches/jumps finish here
// ST_MEM    | data access for lw/sw, held until dmem_ready
// ST_WB     | register file write-back
// ST_HALT   | illegal instruction seen; left only by reset
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic      clk,
   input  logic      rst,
   mc_ctrl_if.master bus
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   instr_cls_t dec_cls;
   logic [3:0] dec_alu_op;
   logic       dec_ext_op, dec_src_a, dec_src_b;

   mc_decode u_decode (
      .op        (bus.Op),
      .funct     (bus.Funct),
      .cls       (dec_cls),
      .alu_op    (dec_alu_op),
      .ext_op    (dec_ext_op),
      .alu_src_a (dec_src_a),
      .alu_src_b (dec_src_b)
   );

   always_comb begin
      state_d      = state_q;
      retired_d    = retired_q;
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.RegWrite = 1'b0;
      bus.MemWrite = 1'b0;
      bus.EXTOp    = 1'b0;
      bus.ALUOp    = ALU_NOP;
      bus.NPCOp    = NPC_PC4;
      bus.ALUSrcA  = 1'b0;
      bus.ALUSrcB  = 1'b0;
      bus.GPRSel   = GPR_RD;
      bus.WDSel    = WD_ALU;
      // ALU selects stay valid through MEM/WB so the address/result remain stable.
      if (state_q == ST_EXE || state_q == ST_MEM || state_q == ST_WB) begin
         bus.ALUOp   = dec_alu_op;
         bus.EXTOp   = dec_ext_op;
         bus.ALUSrcA = dec_src_a;
         bus.ALUSrcB = dec_src_b;
      end
      case (state_q)
         ST_FETCH: begin
            // FETCH is the reset state; qualifying with rst keeps all strobes low during reset.
            if (rst) begin
               bus.imem_req = 1'b1;
               if (bus.imem_ready) begin
                  bus.IRWrite = 1'b1;
                  bus.PCWrite = 1'b1;
                  state_d     = ST_DECODE;
               end
            end
         end
         ST_DECODE: state_d = ST_EXE;
         ST_EXE: begin
            state_d = ST_FETCH;
            case (dec_cls)
               IC_RTYPE, IC_IALU: state_d = ST_WB;
               IC_LW, IC_SW:      state_d = ST_MEM;
               IC_JR:  begin bus.PCWrite = 1'b1;      bus.NPCOp = NPC_JR; end
               IC_BEQ: begin bus.PCWrite = bus.Zero;  bus.NPCOp = NPC_BR; end
               IC_BNE: begin bus.PCWrite = !bus.Zero; bus.NPCOp = NPC_BR; end
               IC_J:   begin bus.PCWrite = 1'b1;      bus.NPCOp = NPC_J;  end
               IC_JAL: begin
                  bus.PCWrite  = 1'b1;
                  bus.NPCOp    = NPC_J;
                  bus.RegWrite = 1'b1;
                  bus.GPRSel   = GPR_R31;
                  bus.WDSel    = WD_PC;
               end
               default: begin
`ifdef MC_CTRL_ILLEGAL_HALT_EN
                  state_d = ST_HALT;
`else
                  state_d = ST_FETCH;
`endif
               end
            endcase
         end
         ST_MEM: begin
            bus.dmem_req = 1'b1;
            bus.MemWrite = (dec_cls == IC_SW);
            if (bus.dmem_ready) state_d = (dec_cls == IC_LW) ? ST_WB : ST_FETCH;
         end
         ST_WB: begin
            bus.RegWrite = 1'b1;
            bus.GPRSel   = (dec_cls == IC_RTYPE) ? GPR_RD : GPR_RT;
            bus.WDSel    = (dec_cls == IC_LW) ? WD_MEM : WD_ALU;
            state_d      = ST_FETCH;
         end
`ifdef MC_CTRL_ILLEGAL_HALT_EN
         ST_HALT: state_d = ST_HALT;
`endif
         default: state_d = ST_FETCH;
      endcase
      if (state_d == ST_FETCH && state_q != ST_FETCH) retired_d = retired_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   assign bus.retired = retired_q;
`ifdef MC_CTRL_ILLEGAL_HALT_EN
   assign bus.halted = (state_q == ST_HALT);
`else
   assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle against hand-computed strobes.
`timescale 1ns/1ps
module tb_mc_ctrl;
   import mc_pkg::*;

   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic rst;

   mc_ctrl_if #(.CNT_W(CNT_W)) bus ();
   mc_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // {imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite}
   function automatic logic [31:0] strobes();
      return 32'({bus.imem_req, bus.dmem_req, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite});
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // FETCH (after optional imem wait cycles) and DECODE; returns positioned in EXE.
   task automatic do_fetch(input string tag, input logic [5:0] op, input logic [5:0] fn, input int waits);
      bus.Op    = op;
      bus.Funct = fn;
      for (int i = 0; i < waits; i++) begin
         bus.imem_ready = 1'b0;
         #1;
         check_val({tag, " fetch wait"}, strobes(), 32'h20);
         step();
      end
      bus.imem_ready = 1'b1;
      #1;
      check_val({tag, " fetch"}, strobes(), 32'h2C);
      check_val({tag, " fetch npc"}, 32'(bus.NPCOp), 32'(NPC_PC4));
      step();
      bus.imem_ready = 1'b0;
      #1;
      check_val({tag, " decode"}, strobes(), 32'h00);
      step();
   endtask

   task automatic expect_fetch(input string tag, input int ret);
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      #1;
      check_val({tag, " back in fetch"}, strobes(), 32'h20);
      check_val({tag, " retired"}, bus.retired, 32'(ret));
   endtask

   initial begin
      rst            = 1'b0;
      bus.Op         = 6'h00;
      bus.Funct      = 6'h00;
      bus.Zero       = 1'b0;
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      step();
      step();
      check_val("reset strobes", strobes(), 32'h00);
      check_val("reset retired", bus.retired, 32'd0);
      check_val("reset halted", 32'(bus.halted), 32'd0);
      rst = 1'b1;
      expect_fetch("post reset", 0);

      // addu: 4 cycles
      do_fetch("addu", OP_RTYPE, FN_ADDU, 0);
      #1;
      check_val("addu exe strobes", strobes(), 32'h00);
      check_val("addu exe aluop", 32'(bus.ALUOp), 32'(ALU_ADD));
      check_val("addu exe srca", 32'(bus.ALUSrcA), 32'd0);
      step();
      #1;
      check_val("addu wb strobes", strobes(), 32'h02);
      check_val("addu wb gprsel", 32'(bus.GPRSel), 32'd0);
      check_val("addu wb wdsel", 32'(bus.WDSel), 32'd0);
      step();
      expect_fetch("addu", 1);

      // lw with dmem_ready low 3 cycles: 8 cycles total
      do_fetch("lw", OP_LW, 6'h00, 0);
      #1;
      check_val("lw exe aluop", 32'(bus.ALUOp), 32'(ALU_ADD));
      check_val("lw exe srcb", 32'(bus.ALUSrcB), 32'd1);
      check_val("lw exe extop", 32'(bus.EXTOp), 32'd1);
      step();
      for (int i = 0; i < 4; i++) begin
         bus.dmem_ready = (i == 3);
         #1;
         check_val("lw mem strobes", strobes(), 32'h10);
         step();
      end
      bus.dmem_ready = 1'b0;
      #1;
      check_val("lw wb strobes", strobes(), 32'h02);
      check_val("lw wb wdsel", 32'(bus.WDSel), 32'd1);
      check_val("lw wb gprsel", 32'(bus.GPRSel), 32'd1);
      step();
      expect_fetch("lw", 2);

      // beq taken then not taken: 3 cycles each
      do_fetch("beq z1", OP_BEQ, 6'h00, 0);
      bus.Zero = 1'b1;
      #1;
      check_val("beq z1 exe strobes", strobes(), 32'h04);
      check_val("beq z1 npcop", 32'(bus.NPCOp), 32'(NPC_BR));
      check_val("beq z1 aluop", 32'(bus.ALUOp), 32'(ALU_SUB));
      step();
      expect_fetch("beq z1", 3);
      do_fetch("beq z0", OP_BEQ, 6'h00, 0);
      bus.Zero = 1'b0;
      #1;
      check_val("beq z0 exe strobes", strobes(), 32'h00);
      check_val("beq z0 npcop", 32'(bus.NPCOp), 32'(NPC_BR));
      step();
      expect_fetch("beq z0", 4);

      // jal: 3 cycles
      do_fetch("jal", OP_JAL, 6'h00, 0);
      #1;
      check_val("jal exe strobes", strobes(), 32'h06);
      check_val("jal npcop", 32'(bus.NPCOp), 32'(NPC_J));
      check_val("jal gprsel", 32'(bus.GPRSel), 32'd2);
      check_val("jal wdsel", 32'(bus.WDSel), 32'd2);
      step();
      expect_fetch("jal", 5);

      // sll: shamt operand
      do_fetch("sll", OP_RTYPE, FN_SLL, 0);
      #1;
      check_val("sll exe aluop", 32'(bus.ALUOp), 32'(ALU_SLL));
      check_val("sll exe srca", 32'(bus.ALUSrcA), 32'd1);
      step();
      #1;
      check_val("sll wb strobes", strobes(), 32'h02);
      step();
      expect_fetch("sll", 6);

      // ori with two imem wait cycles
      do_fetch("ori", OP_ORI, 6'h00, 2);
      #1;
      check_val("ori exe aluop", 32'(bus.ALUOp), 32'(ALU_OR));
      check_val("ori exe extop", 32'(bus.EXTOp), 32'd0);
      check_val("ori exe srcb", 32'(bus.ALUSrcB), 32'd1);
      step();
      #1;
      check_val("ori wb strobes", strobes(), 32'h02);
      check_val("ori wb gprsel", 32'(bus.GPRSel), 32'd1);
      check_val("ori wb wdsel", 32'(bus.WDSel), 32'd0);
      step();
      expect_fetch("ori", 7);

      // illegal opcode
      do_fetch("illegal", 6'h3F, 6'h00, 0);
      #1;
      check_val("illegal exe strobes", strobes(), 32'h00);
      step();
`ifdef MC_CTRL_ILLEGAL_HALT_EN
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         check_val("halt strobes", strobes(), 32'h00);
         check_val("halt flag", 32'(bus.halted), 32'd1);
         step();
      end
      check_val("halt retired", bus.retired, 32'd7);
`else
      expect_fetch("illegal", 8);
      check_val("illegal halted", 32'(bus.halted), 32'd0);
`endif

      // clean reset (also the only exit from HALT)
      rst = 1'b0;
      step();
      rst = 1'b1;
      expect_fetch("reset2", 0);
      check_val("reset2 halted", 32'(bus.halted), 32'd0);

      // sw interrupted by reset while stalled in MEM
      do_fetch("sw rst", OP_SW, 6'h00, 0);
      step();
      bus.dmem_ready = 1'b0;
      #1;
      check_val("sw mem strobes", strobes(), 32'h11);
      step();
      #1;
      check_val("sw mem hold strobes", strobes(), 32'h11);
      rst = 1'b0;
      #1;
      check_val("sw mid-reset strobes", strobes(), 32'h00);
      check_val("sw mid-reset retired", bus.retired, 32'd0);
      step();
      rst = 1'b1;
      expect_fetch("sw after reset", 0);

      // full sw: 4 cycles
      do_fetch("sw", OP_SW, 6'h00, 0);
      step();
      bus.dmem_ready = 1'b1;
      #1;
      check_val("sw mem strobes ready", strobes(), 32'h11);
      step();
      expect_fetch("sw", 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
